// File: rtl/pixel_pkg.sv
// Shared types for the BRAM pixel writer: FSM states, colour formats and address width.
package pixel_pkg;

  localparam int ADDR_W = 19;

  typedef enum logic [1:0] {
    WAIT_SOF   = 2'd0,
    RECEIVE    = 2'd1,
    FRAME_DONE = 2'd2
  } writer_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb666_t;

  // Plain truncation: the two LSBs of each colour are dropped, never rounded.
  function automatic rgb666_t to_rgb666(input rgb888_t p);
    rgb666_t q;
    q.r = p.r[7:2];
    q.g = p.g[7:2];
    q.b = p.b[7:2];
    return q;
  endfunction

endpackage

// File: rtl/pixel_xy_counter.sv
// Raster position tracker: x/y with line wrap plus a running linear address (no multiplier).
module pixel_xy_counter
  import pixel_pkg::*;
#(
  parameter int H_SIZE = 607,
  parameter int V_SIZE = 455
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_first,
  input  logic              advance,
  output logic [ADDR_W-1:0] address,
  output logic              at_last
);

  localparam int X_W = (H_SIZE > 1) ? $clog2(H_SIZE) : 1;
  localparam int Y_W = (V_SIZE > 1) ? $clog2(V_SIZE) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_SIZE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_SIZE - 1);

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  // load_first positions the counters just past pixel 0, which the caller writes itself.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x       <= '0;
      y       <= '0;
      address <= '0;
    end else if (load_first) begin
      x       <= X_W'(1);
      y       <= '0;
      address <= ADDR_W'(1);
    end else if (advance) begin
      address <= address + 1'b1;
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign at_last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/bram_pixel_writer.sv
// Streams RGB888 pixels into a BRAM as RGB666, one registered write per accepted beat.
// Define SOF_RESYNC_EN to let a pix_sof beat in mid-frame restart the frame at address 0.
module bram_pixel_writer
  import pixel_pkg::*;
#(
  parameter int H_SIZE = 607,
  parameter int V_SIZE = 455
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [23:0]       pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic              w_enable,
  output logic [ADDR_W-1:0] w_address,
  output logic [17:0]       w_data,
  output logic              frame_done
);

  writer_state_t     state_q, state_d;
  logic              beat;
  logic              wr_en_d, done_d;
  logic [ADDR_W-1:0] wr_addr_d;
  rgb666_t           wr_data_d;
  logic              cnt_clear, cnt_load, cnt_adv;
  logic [ADDR_W-1:0] cnt_address;
  logic              cnt_at_last;

  pixel_xy_counter #(
    .H_SIZE(H_SIZE),
    .V_SIZE(V_SIZE)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .load_first(cnt_load),
    .advance   (cnt_adv),
    .address   (cnt_address),
    .at_last   (cnt_at_last)
  );

  assign pix_ready = (state_q != FRAME_DONE);
  assign beat      = pix_valid & pix_ready;
  assign wr_data_d = to_rgb666(pix_data);

  always_ff @(posedge clk) begin
    if (reset) state_q <= WAIT_SOF;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    done_d    = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_adv   = 1'b0;
    case (state_q)
      WAIT_SOF: begin
        if (beat && pix_sof) begin
          wr_en_d  = 1'b1;
          cnt_load = 1'b1;
          state_d  = RECEIVE;
        end
      end
      RECEIVE: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_address;
          if (cnt_at_last) begin
            done_d    = 1'b1;
            cnt_clear = 1'b1;
            state_d   = FRAME_DONE;
          end else begin
            cnt_adv = 1'b1;
          end
`ifdef SOF_RESYNC_EN
          // A fresh start-of-frame overrides everything above; the aborted frame gets no done pulse.
          if (pix_sof) begin
            wr_addr_d = '0;
            done_d    = 1'b0;
            cnt_clear = 1'b0;
            cnt_adv   = 1'b0;
            cnt_load  = 1'b1;
            state_d   = RECEIVE;
          end
`endif
        end
      end
      FRAME_DONE: state_d = WAIT_SOF;
      default:    state_d = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_enable   <= 1'b0;
      w_address  <= '0;
      w_data     <= '0;
      frame_done <= 1'b0;
    end else begin
      w_enable   <= wr_en_d;
      frame_done <= done_d;
      if (wr_en_d) begin
        w_address <= wr_addr_d;
        w_data    <= wr_data_d;
      end
    end
  end

endmodule

// File: doc/bram_pixel_writer.md
BRAM_PIXEL_WRITER -- requirements
Module: bram_pixel_writer

Interface
REQ-001 Parameter H_SIZE, default 607, image width in pixels.
REQ-002 Parameter V_SIZE, default 455, image height in lines.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 pix_data  input  24  incoming pixel {R[7:0],G[7:0],B[7:0]}.
REQ-006 pix_valid  input  1  pix_data/pix_sof valid this cycle.
REQ-007 pix_sof  input  1  marks first pixel of a frame; qualified by pix_valid.
REQ-008 pix_ready  output  1  block accepts a beat this cycle (beat = pix_valid & pix_ready).
REQ-009 w_enable  output  1  BRAM write strobe.
REQ-010 w_address  output  19  BRAM write address.
REQ-011 w_data  output  18  BRAM write data, 6 bits per colour.
REQ-012 frame_done  output  1  one-cycle pulse, last pixel of frame written.

Function
REQ-013 States: WAIT_SOF, RECEIVE, FRAME_DONE; pix_ready SHALL be 1 in WAIT_SOF and RECEIVE, 0 in FRAME_DONE, decoded from the state register only.
REQ-014 WAIT_SOF: beat with pix_sof=1 SHALL write the pixel at address 0, set x=1, y=0 and go to RECEIVE; beats with pix_sof=0 are consumed and dropped (no write).
REQ-015 RECEIVE: each beat SHALL write at the running address, then increment address and x; at x==H_SIZE-1, x wraps to 0 and y increments.
REQ-016 The beat with x==H_SIZE-1 and y==V_SIZE-1 SHALL be written, then the block goes to FRAME_DONE, clearing x, y and the address to 0.
REQ-017 FRAME_DONE SHALL last exactly one cycle, then return to WAIT_SOF.
REQ-018 w_enable, w_address and w_data SHALL be registered and appear exactly 1 cycle after the accepting beat; w_enable is 0 in all other cycles.
REQ-019 w_data SHALL be {R[7:2],G[7:2],B[7:2]}; this is truncation with no rounding.
REQ-020 The address SHALL come from a running counter with no multiplier, and SHALL equal y*H_SIZE+x for every write.
REQ-021 frame_done SHALL be 1 in the same cycle as w_enable for the last pixel of the frame, and 0 otherwise.
REQ-022 Cycles with pix_valid=0 SHALL hold x, y, the address and the state unchanged.

Reset
REQ-023 On reset: state=WAIT_SOF, x=y=0, address=0, w_enable=0, w_address=0, w_data=0, frame_done=0.
REQ-024 Reset mid-frame SHALL abandon the frame without a further write or a frame_done pulse; the next frame starts only on a new pix_sof.

Configuration
REQ-025 Macro SOF_RESYNC_EN defined: a pix_sof beat in RECEIVE SHALL restart the frame, writing that pixel at address 0 and setting x=1, y=0; no frame_done is issued for the aborted frame.
REQ-026 Macro SOF_RESYNC_EN undefined: pix_sof SHALL be ignored in RECEIVE, and the beat is written as an ordinary pixel.

Structure
REQ-027 Package pixel_pkg SHALL hold the state enum, rgb888_t/rgb666_t typedefs and the ADDR_W=19 constant.
REQ-028 Sub-module pixel_xy_counter (x/y/address counters with wrap and clear) is the natural split; the FSM and data path stay in bram_pixel_writer.

Verification (H_SIZE=4, V_SIZE=3 unless stated)
REQ-029 Reset, then a continuous 12-beat frame, first beat sof=1 -> 12 writes at addresses 0..11 on consecutive cycles, each 1 cycle after its beat; frame_done together with the address-11 write; pix_ready=0 for one cycle afterwards.
REQ-030 pix_data=24'hFF8003 -> w_data=18'h3F800 (R=3F, G=20, B=00).
REQ-031 3 beats with sof=0 in WAIT_SOF, then a sof frame -> no writes for the first 3 beats; first write at address 0.
REQ-032 pix_valid toggled randomly during a frame -> addresses still 0..11 in order, with no gaps or duplicates.
REQ-033 Second sof at beat 6: with SOF_RESYNC_EN -> write at address 0 and no frame_done for the aborted frame; without SOF_RESYNC_EN -> write at address 6.
REQ-034 Reset asserted after beat 5 -> no further write or frame_done; the next sof frame writes from address 0.
